// File: rtl/count_sequencer.sv
// rtl/count_sequencer.sv - prescaled BCD count sequencer with run/pause/done control
module count_sequencer #(
   parameter int TICK_DIV = 25000000
) (
   input  logic       Clk,
   input  logic       RST,
   input  logic       Start,
   input  logic       Stop,
   input  logic       Clear,
   input  logic       Mode,
   input  logic [1:0] Rate,
   input  logic [3:0] Limit,
   output logic [3:0] OUT,
   output logic       Tick,
   output logic       Wrap,
   output logic       Done,
   output logic [1:0] State
);

   localparam int PW = $clog2(TICK_DIV + 1);
   localparam logic [PW-1:0] DIV = PW'(TICK_DIV);

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_RUN   = 2'b01,
      S_PAUSE = 2'b10,
      S_DONE  = 2'b11
   } state_t;

   state_t        state;
   logic [PW-1:0] presc;
   logic          mode_q;
   logic [3:0]    limit_q;
   logic [1:0]    rate_q;
   logic [3:0]    limit_clamped;
   logic [PW-1:0] presc_last;

   // Terminal count is a single BCD digit, so anything above 9 is treated as 9.
   assign limit_clamped = (Limit > 4'd9) ? 4'd9 : Limit;

   // Last prescaler value of a period; uses the rate latched at the previous reload.
   assign presc_last = (DIV >> rate_q) - PW'(1);

   assign State = state;

   // Control FSM, prescaler and count; Stop outranks Start, so a Stop in the
   // same cycle suppresses any Start even in states where Stop itself is a no-op.
   always_ff @(posedge Clk) begin
      Tick <= 1'b0;
      Wrap <= 1'b0;
      if (RST) begin
         state   <= S_IDLE;
         OUT     <= 4'd0;
         presc   <= '0;
         Done    <= 1'b0;
         mode_q  <= 1'b0;
         limit_q <= 4'd9;
         rate_q  <= 2'd0;
      end else if (Clear) begin
         state <= S_IDLE;
         OUT   <= 4'd0;
         presc <= '0;
         Done  <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (!Stop && Start) begin
                  state   <= S_RUN;
                  OUT     <= 4'd0;
                  presc   <= '0;
                  Done    <= 1'b0;
                  mode_q  <= Mode;
                  limit_q <= limit_clamped;
                  rate_q  <= Rate;
               end
            end
            S_RUN: begin
               if (Stop) begin
                  state <= S_PAUSE;
               end else if (presc == presc_last) begin
                  presc  <= '0;
                  rate_q <= Rate;
                  Tick   <= 1'b1;
                  if (OUT < limit_q) begin
                     OUT <= OUT + 4'd1;
                  end else if (!mode_q) begin
                     OUT  <= 4'd0;
                     Wrap <= 1'b1;
                  end else begin
                     state <= S_DONE;
                     Done  <= 1'b1;
                  end
               end else begin
                  presc <= presc + PW'(1);
               end
            end
            S_PAUSE: begin
               if (!Stop && Start) begin
                  state <= S_RUN;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_count_sequencer.sv
// tb/tb_count_sequencer.sv - directed self-checking bench for count_sequencer
module tb_count_sequencer;

   logic       Clk = 1'b0;
   logic       RST;
   logic       Start;
   logic       Stop;
   logic       Clear;
   logic       Mode;
   logic [1:0] Rate;
   logic [3:0] Limit;
   logic [3:0] OUT;
   logic       Tick;
   logic       Wrap;
   logic       Done;
   logic [1:0] State;

   int checks = 0;
   int errors = 0;

   localparam logic [1:0] ST_IDLE  = 2'b00;
   localparam logic [1:0] ST_RUN   = 2'b01;
   localparam logic [1:0] ST_PAUSE = 2'b10;
   localparam logic [1:0] ST_DONE  = 2'b11;

   count_sequencer #(.TICK_DIV(8)) dut (
      .Clk   (Clk),
      .RST   (RST),
      .Start (Start),
      .Stop  (Stop),
      .Clear (Clear),
      .Mode  (Mode),
      .Rate  (Rate),
      .Limit (Limit),
      .OUT   (OUT),
      .Tick  (Tick),
      .Wrap  (Wrap),
      .Done  (Done),
      .State (State)
   );

   always #5 Clk = ~Clk;

   initial begin
      #1000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge Clk);
   endtask

   task automatic pulse_start(input logic m, input logic [3:0] l, input logic [1:0] r);
      Mode = m; Limit = l; Rate = r; Start = 1'b1;
      cyc(1);
      Start = 1'b0;
   endtask

   task automatic pulse_clear();
      Clear = 1'b1;
      cyc(1);
      Clear = 1'b0;
   endtask

   task automatic wait_tick(input int budget, output int n);
      n = 0;
      do begin
         cyc(1);
         n++;
      end while (Tick !== 1'b1 && n < budget);
   endtask

   task automatic test_reset();
      RST = 1'b1; Start = 1'b1;
      cyc(2);
      RST = 1'b0; Start = 1'b0;
      checks++; if (State !== ST_IDLE) begin errors++; $display("FAIL reset_state got %0d want 0", State); end
      checks++; if (OUT !== 4'd0) begin errors++; $display("FAIL reset_out got %0d want 0", OUT); end
      checks++; if ({Tick, Wrap, Done} !== 3'b000) begin errors++; $display("FAIL reset_pulses got %b want 000", {Tick, Wrap, Done}); end
      cyc(1);
      checks++; if (State !== ST_IDLE) begin errors++; $display("FAIL reset_hold got %0d want 0", State); end
   endtask

   task automatic test_continuous();
      int n;
      pulse_start(1'b0, 4'd9, 2'd0);
      checks++; if (State !== ST_RUN || OUT !== 4'd0) begin errors++; $display("FAIL cont_start got st=%0d out=%0d want st=1 out=0", State, OUT); end
      for (int i = 1; i <= 10; i++) begin
         wait_tick(8, n);
         checks++; if (n !== 8 || Tick !== 1'b1) begin errors++; $display("FAIL cont_period got %0d want 8", n); end
         checks++; if (OUT !== 4'(i % 10)) begin errors++; $display("FAIL cont_out got %0d want %0d", OUT, i % 10); end
         checks++; if (Wrap !== (i == 10)) begin errors++; $display("FAIL cont_wrap got %b want %b", Wrap, (i == 10)); end
      end
      cyc(1);
      checks++; if ({Tick, Wrap} !== 2'b00) begin errors++; $display("FAIL cont_pulse_width got %b want 00", {Tick, Wrap}); end
   endtask

   task automatic test_one_shot();
      int n;
      pulse_clear();
      pulse_start(1'b1, 4'd3, 2'd1);
      for (int i = 1; i <= 4; i++) begin
         wait_tick(4, n);
         checks++; if (n !== 4 || Tick !== 1'b1) begin errors++; $display("FAIL shot_period got %0d want 4", n); end
         checks++; if (OUT !== 4'((i < 4) ? i : 3)) begin errors++; $display("FAIL shot_out got %0d want %0d", OUT, (i < 4) ? i : 3); end
         checks++; if (State !== ((i < 4) ? ST_RUN : ST_DONE) || Done !== (i == 4)) begin errors++; $display("FAIL shot_state got st=%0d done=%b want st=%0d done=%b", State, Done, (i < 4) ? 1 : 3, (i == 4)); end
      end
      cyc(6);
      checks++; if (State !== ST_DONE || OUT !== 4'd3 || Done !== 1'b1 || Tick !== 1'b0) begin errors++; $display("FAIL shot_hold got st=%0d out=%0d done=%b tick=%b want st=3 out=3 done=1 tick=0", State, OUT, Done, Tick); end
      pulse_start(1'b0, 4'd9, 2'd0);
      checks++; if (State !== ST_RUN || OUT !== 4'd0 || Done !== 1'b0) begin errors++; $display("FAIL shot_restart got st=%0d out=%0d done=%b want st=1 out=0 done=0", State, OUT, Done); end
   endtask

   task automatic test_pause();
      int n;
      int bad;
      wait_tick(8, n);
      checks++; if (n !== 8 || OUT !== 4'd1) begin errors++; $display("FAIL pause_pre got n=%0d out=%0d want n=8 out=1", n, OUT); end
      cyc(3);
      Stop = 1'b1;
      cyc(1);
      Stop = 1'b0;
      checks++; if (State !== ST_PAUSE || OUT !== 4'd1) begin errors++; $display("FAIL pause_enter got st=%0d out=%0d want st=2 out=1", State, OUT); end
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         cyc(1);
         if (Tick !== 1'b0 || OUT !== 4'd1 || State !== ST_PAUSE) bad++;
      end
      checks++; if (bad !== 0) begin errors++; $display("FAIL pause_hold got %0d bad cycles want 0", bad); end
      Start = 1'b1;
      cyc(1);
      Start = 1'b0;
      checks++; if (State !== ST_RUN) begin errors++; $display("FAIL pause_resume got %0d want 1", State); end
      wait_tick(10, n);
      checks++; if (n !== 5 || Tick !== 1'b1) begin errors++; $display("FAIL pause_latency got %0d want 5", n); end
      checks++; if (OUT !== 4'd2) begin errors++; $display("FAIL pause_next_out got %0d want 2", OUT); end
   endtask

   task automatic test_priority();
      Start = 1'b1; Stop = 1'b1; Clear = 1'b1;
      cyc(1);
      Start = 1'b0; Stop = 1'b0; Clear = 1'b0;
      checks++; if (State !== ST_IDLE || OUT !== 4'd0) begin errors++; $display("FAIL prio_clear got st=%0d out=%0d want st=0 out=0", State, OUT); end
      pulse_start(1'b0, 4'd9, 2'd0);
      Stop = 1'b1;
      cyc(1);
      Stop = 1'b0;
      checks++; if (State !== ST_PAUSE) begin errors++; $display("FAIL prio_stop got %0d want 2", State); end
      Stop = 1'b1; Start = 1'b1;
      cyc(1);
      Stop = 1'b0; Start = 1'b0;
      checks++; if (State !== ST_PAUSE) begin errors++; $display("FAIL prio_stop_start got %0d want 2", State); end
   endtask

   task automatic test_limit_clamp();
      int n;
      logic [3:0] exp_out;
      pulse_clear();
      pulse_start(1'b0, 4'd12, 2'd0);
      Limit = 4'd2; Mode = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         wait_tick(8, n);
         checks++; if (n !== 8 || OUT !== 4'(i % 10) || Wrap !== (i == 10) || State !== ST_RUN) begin errors++; $display("FAIL clamp_tick%0d got n=%0d out=%0d wrap=%b st=%0d want n=8 out=%0d wrap=%b st=1", i, n, OUT, Wrap, State, i % 10, (i == 10)); end
      end
      pulse_clear();
      pulse_start(1'b0, 4'd2, 2'd0);
      for (int i = 1; i <= 3; i++) begin
         exp_out = (i == 3) ? 4'd0 : 4'(i);
         wait_tick(8, n);
         checks++; if (n !== 8 || OUT !== exp_out || Wrap !== (i == 3)) begin errors++; $display("FAIL limit2_tick%0d got n=%0d out=%0d wrap=%b want n=8 out=%0d wrap=%b", i, n, OUT, Wrap, exp_out, (i == 3)); end
      end
   endtask

   task automatic test_limit_zero();
      int n;
      pulse_clear();
      pulse_start(1'b0, 4'd0, 2'd2);
      for (int i = 1; i <= 3; i++) begin
         wait_tick(2, n);
         checks++; if (n !== 2 || OUT !== 4'd0 || Wrap !== 1'b1) begin errors++; $display("FAIL zero_cont got n=%0d out=%0d wrap=%b want n=2 out=0 wrap=1", n, OUT, Wrap); end
      end
      pulse_clear();
      pulse_start(1'b1, 4'd0, 2'd2);
      wait_tick(2, n);
      checks++; if (n !== 2 || State !== ST_DONE || Done !== 1'b1 || OUT !== 4'd0 || Wrap !== 1'b0) begin errors++; $display("FAIL zero_shot got n=%0d st=%0d done=%b out=%0d wrap=%b want n=2 st=3 done=1 out=0 wrap=0", n, State, Done, OUT, Wrap); end
   endtask

   task automatic test_reset_midrun();
      int n;
      int ticks;
      pulse_clear();
      pulse_start(1'b0, 4'd9, 2'd0);
      repeat (5) wait_tick(8, n);
      checks++; if (OUT !== 4'd5) begin errors++; $display("FAIL rst_mid_pre got %0d want 5", OUT); end
      cyc(2);
      RST = 1'b1;
      cyc(1);
      RST = 1'b0;
      checks++; if (State !== ST_IDLE || OUT !== 4'd0 || Tick !== 1'b0 || Done !== 1'b0) begin errors++; $display("FAIL rst_mid got st=%0d out=%0d tick=%b done=%b want st=0 out=0 tick=0 done=0", State, OUT, Tick, Done); end
      ticks = 0;
      for (int i = 0; i < 20; i++) begin
         cyc(1);
         if (Tick === 1'b1) ticks++;
      end
      checks++; if (ticks !== 0) begin errors++; $display("FAIL rst_mid_quiet got %0d ticks want 0", ticks); end
      pulse_start(1'b0, 4'd9, 2'd0);
      wait_tick(8, n);
      checks++; if (n !== 8 || OUT !== 4'd1) begin errors++; $display("FAIL rst_mid_restart got n=%0d out=%0d want n=8 out=1", n, OUT); end
   endtask

   initial begin
      RST = 1'b0; Start = 1'b0; Stop = 1'b0; Clear = 1'b0;
      Mode = 1'b0; Rate = 2'd0; Limit = 4'd9;
      test_reset();
      test_continuous();
      test_one_shot();
      test_pause();
      test_priority();
      test_limit_clamp();
      test_limit_zero();
      test_reset_midrun();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/count_sequencer.md
COUNT_SEQUENCER -- requirements
Module: count_sequencer

Parameters
REQ-001 SHALL have parameter TICK_DIV, default 25000000: base prescaler divide ratio (one count per second / 2 at 50 MHz); legal range >= 8.

Interface
REQ-002 SHALL have port Clk, input, 1 bit: sole clock, rising edge.
REQ-003 SHALL have port RST, input, 1 bit: reset, synchronous, active-high.
REQ-004 SHALL have port Start, input, 1 bit: single-cycle start/resume request.
REQ-005 SHALL have port Stop, input, 1 bit: single-cycle pause request.
REQ-006 SHALL have port Clear, input, 1 bit: single-cycle abort-to-idle request.
REQ-007 SHALL have port Mode, input, 1 bit: 0 = continuous wrap, 1 = one-shot.
REQ-008 SHALL have port Rate, input, 2 bits: prescaler divide = TICK_DIV >> Rate.
REQ-009 SHALL have port Limit, input, 4 bits: terminal count; values > 9 clamp to 9.
REQ-010 SHALL have port OUT, output, 4 bits: current count, BCD digit 0..9.
REQ-011 SHALL have port Tick, output, 1 bit: one-cycle pulse, count advanced.
REQ-012 SHALL have port Wrap, output, 1 bit: one-cycle pulse, continuous-mode wrap to 0.
REQ-013 SHALL have port Done, output, 1 bit: level, high while in DONE.
REQ-014 SHALL have port State, output, 2 bits: IDLE=00, RUN=01, PAUSE=10, DONE=11.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, PAUSE, DONE; all outputs registered.
REQ-016 SHALL apply command priority RST > Clear > Stop > Start when several are high in one cycle.
REQ-017 Clear SHALL, in any state, go to IDLE with OUT=0, prescaler=0 on the next edge.
REQ-018 Start in IDLE or DONE SHALL go to RUN, set OUT=0, prescaler=0, and latch Mode, clamped Limit and Rate.
REQ-019 Start in RUN SHALL be ignored; Start in PAUSE SHALL return to RUN with OUT and prescaler unchanged.
REQ-020 Stop in RUN SHALL go to PAUSE, holding OUT and prescaler; Stop in other states SHALL be ignored.
REQ-021 In RUN the prescaler SHALL increment each cycle; at value N-1 (N = TICK_DIV >> Rate_latched) it SHALL reload 0, relatch Rate, and advance the count.
REQ-022 Advance SHALL update OUT and assert Tick on the same edge; Tick is high for exactly that one cycle.
REQ-023 Advance with OUT < Limit_latched SHALL set OUT = OUT+1.
REQ-024 Advance with OUT == Limit_latched and Mode_latched=0 SHALL set OUT=0 and pulse Wrap with Tick.
REQ-025 Advance with OUT == Limit_latched and Mode_latched=1 SHALL hold OUT, go to DONE, pulse Tick.
REQ-026 Limit=0 SHALL be legal: continuous wraps 0->0 every tick; one-shot reaches DONE after first tick.
REQ-027 Mode and Limit changes after Start SHALL have no effect until the next Start from IDLE/DONE.
REQ-028 OUT SHALL never exceed 9 under any input sequence.
REQ-029 Tick, Wrap SHALL be 0 in every cycle outside an advance.

Reset
REQ-030 RST high at a rising edge SHALL force State=IDLE, OUT=0, prescaler=0, Tick=0, Wrap=0, Done=0, latched Mode=0, Limit=9, Rate=0.
REQ-031 RST SHALL override every other input, including mid-count and in the Start cycle.

Verification (TICK_DIV=8)
REQ-032 Bench SHALL check: RST, Start, Mode=0, Limit=9, Rate=0 -> Tick every 8 cycles, OUT 0..9, Wrap with OUT 9->0 on the 10th tick.
REQ-033 Bench SHALL check: Mode=1, Limit=3, Rate=1 -> Tick every 4 cycles, OUT 1,2,3, then State=DONE, Done=1, OUT held at 3; Start -> OUT=0, RUN.
REQ-034 Bench SHALL check: Stop 3 cycles after a tick, wait 20 cycles, Start -> OUT unchanged during PAUSE, next Tick exactly 5 cycles after resume.
REQ-035 Bench SHALL check: Start+Stop+Clear in the same cycle while in RUN -> IDLE, OUT=0; Stop+Start in PAUSE -> stays PAUSE.
REQ-036 Bench SHALL check: Limit=12 -> behaves as 9; Limit changed to 2 mid-run -> ignored until restart.
REQ-037 Bench SHALL check: RST asserted at OUT=5 in RUN -> next cycle State=IDLE, OUT=0; no Tick until a new Start.
